bp_be_hazard_tracker: RTL



---
 rtl/bp_be_hazard_tracker.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bp_be_hazard_tracker.sv
// Issue-side hazard tracker for the backend: shadows in-flight destinations down the
// pipe and keeps per-register-file scoreboards of long-latency writes awaiting writeback.
module bp_be_hazard_tracker #(
   parameter  int depth_p          = 4,
   parameter  int num_rs_p         = 3,
   parameter  int long_max_p       = 4,
   parameter  int reg_addr_width_p = 5,
   localparam int lat_width_lp     = $clog2(depth_p + 1),
   localparam int cnt_width_lp     = $clog2(long_max_p + 1),
   localparam int num_regs_lp      = 1 << reg_addr_width_p
) (
   input  logic                                 clk_i,
   input  logic                                 reset_n_i,
   input  logic                                 issue_v_i,
   input  logic [num_rs_p*reg_addr_width_p-1:0] issue_rs_addr_i,
   input  logic [num_rs_p-1:0]                  issue_rs_v_i,
   input  logic [num_rs_p-1:0]                  issue_rs_fp_i,
   input  logic [reg_addr_width_p-1:0]          issue_rd_addr_i,
   input  logic                                 issue_rd_v_i,
   input  logic                                 issue_rd_fp_i,
   input  logic [lat_width_lp-1:0]              issue_lat_i,
   input  logic                                 busy_i,
   input  logic                                 flush_i,
   input  logic                                 clear_v_i,
   input  logic [reg_addr_width_p-1:0]          clear_rd_i,
   input  logic                                 clear_fp_i,
   output logic                                 dispatch_v_o,
   output logic                                 raw_haz_o,
   output logic                                 waw_haz_o,
   output logic                                 struct_haz_o,
   output logic [cnt_width_lp-1:0]              long_cnt_o
);

   localparam logic [lat_width_lp-1:0] long_lat_lp = lat_width_lp'(depth_p);
   localparam logic [cnt_width_lp-1:0] long_max_lp = cnt_width_lp'(long_max_p);

   typedef struct packed {
      logic [reg_addr_width_p-1:0] rd;
      logic                        fp;
      logic [lat_width_lp-1:0]     lat;
   } stage_s;

   stage_s [depth_p-1:0]        stage_q;
   logic   [depth_p-1:0]        stage_v_q;
   logic   [num_regs_lp-1:0]    sb_int_q, sb_fp_q, sb_int_n, sb_fp_n;
   logic   [cnt_width_lp-1:0]   long_cnt_q;
   logic   [reg_addr_width_p-1:0] rs_addr [num_rs_p];
   logic                        load_v, raw_any, waw_any, struct_any;
   logic                        commit_long, long_inc, long_dec;

   // Writes to integer x0 are architecturally dropped, so they are never tracked.
   assign load_v = issue_rd_v_i && (issue_rd_fp_i || (issue_rd_addr_i != '0));

   always_comb begin
      for (int k = 0; k < num_rs_p; k++)
         rs_addr[k] = issue_rs_addr_i[k*reg_addr_width_p +: reg_addr_width_p];
   end

   // NOTE: combinational blocks use '=' and give every output a default first, so no latch is inferred.
   always_comb begin
      raw_any = 1'b0;
      for (int k = 0; k < num_rs_p; k++) begin
         if (issue_rs_v_i[k] && (issue_rs_fp_i[k] || (rs_addr[k] != '0))) begin
            if (issue_rs_fp_i[k] ? sb_fp_q[rs_addr[k]] : sb_int_q[rs_addr[k]])
               raw_any = 1'b1;
            for (int i = 0; i < depth_p; i++) begin
               if (stage_v_q[i] && (stage_q[i].fp == issue_rs_fp_i[k])
                   && (stage_q[i].rd == rs_addr[k])
                   && (stage_q[i].lat > lat_width_lp'(i + 1)))
                  raw_any = 1'b1;
            end
         end
      end
   end

   always_comb begin
      waw_any = 1'b0;
      if (load_v) begin
         if (issue_rd_fp_i ? sb_fp_q[issue_rd_addr_i] : sb_int_q[issue_rd_addr_i])
            waw_any = 1'b1;
         for (int i = 0; i < depth_p; i++) begin
            if (stage_v_q[i] && (stage_q[i].lat == long_lat_lp)
                && (stage_q[i].rd == issue_rd_addr_i) && (stage_q[i].fp == issue_rd_fp_i))
               waw_any = 1'b1;
         end
      end
   end

   assign struct_any   = busy_i || ((issue_lat_i == long_lat_lp) && (long_cnt_q == long_max_lp));
   assign raw_haz_o    = issue_v_i & raw_any;
   assign waw_haz_o    = issue_v_i & waw_any;
   assign struct_haz_o = issue_v_i & struct_any;
   assign dispatch_v_o = issue_v_i & ~raw_any & ~waw_any & ~struct_any & ~flush_i;
   assign long_cnt_o   = long_cnt_q;

   assign commit_long = stage_v_q[depth_p-1] && (stage_q[depth_p-1].lat == long_lat_lp);
   assign long_inc    = commit_long;

   // A clear aimed at the register committing this cycle counts as a real retire,
   // so the pair leaves the counter untouched while the set still lands.
   always_comb begin
      sb_int_n = sb_int_q;
      sb_fp_n  = sb_fp_q;
      long_dec = 1'b0;
      if (clear_v_i) begin
         long_dec = (clear_fp_i ? sb_fp_q[clear_rd_i] : sb_int_q[clear_rd_i])
                 || (commit_long && (stage_q[depth_p-1].fp == clear_fp_i)
                                 && (stage_q[depth_p-1].rd == clear_rd_i));
         if (clear_fp_i) sb_fp_n[clear_rd_i]  = 1'b0;
         else            sb_int_n[clear_rd_i] = 1'b0;
      end
      if (commit_long) begin
         if (stage_q[depth_p-1].fp) sb_fp_n[stage_q[depth_p-1].rd]  = 1'b1;
         else                       sb_int_n[stage_q[depth_p-1].rd] = 1'b1;
      end
   end

   // NOTE: sequential state is updated only with '<=' so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         stage_v_q  <= '0;
         sb_int_q   <= '0;
         sb_fp_q    <= '0;
         long_cnt_q <= '0;
      end else begin
         stage_v_q[0] <= dispatch_v_o & load_v;
         for (int i = 1; i < depth_p; i++)
            stage_v_q[i] <= stage_v_q[i-1] & ~flush_i;
         sb_int_q <= sb_int_n;
         sb_fp_q  <= sb_fp_n;
         if (long_inc && !long_dec && (long_cnt_q != long_max_lp))
            long_cnt_q <= long_cnt_q + 1'b1;
         else if (long_dec && !long_inc && (long_cnt_q != '0))
            long_cnt_q <= long_cnt_q - 1'b1;
      end
   end

   // NOTE: the stage payload is not reset; it is only observed through its reset valid bit.
   always_ff @(posedge clk_i) begin
      stage_q[0] <= '{rd: issue_rd_addr_i, fp: issue_rd_fp_i, lat: issue_lat_i};
      for (int i = 1; i < depth_p; i++)
         stage_q[i] <= stage_q[i-1];
   end

   assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(long_inc && !long_dec && (long_cnt_q == long_max_lp)));
   assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(long_dec && !long_inc && (long_cnt_q == '0)));

endmodule
